// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: time-multiplexed digits with dark gaps,
// double-buffered display value loaded through a valid/ready handshake.
module seg_scan_ctrl #(
  parameter int DIV = 50000,
  parameter int GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  blank_in,
  input  logic        lz_en_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [6:0]  seg,
  output logic [3:0]  dig_en,
  output logic        frame_done
);

  localparam int CMAX = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  typedef enum logic {S_DRIVE, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   act_data_q, act_data_d, pnd_data_q, pnd_data_d;
  logic [3:0]    act_blank_q, act_blank_d, pnd_blank_q, pnd_blank_d;
  logic          act_lz_q, act_lz_d, pnd_lz_q, pnd_lz_d;
  logic          pend_q, pend_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_en_q, dig_en_d;
  logic          frame_done_q, frame_done_d;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    case (nib)
      4'h0: encode = 7'h3F;  4'h1: encode = 7'h06;
      4'h2: encode = 7'h5B;  4'h3: encode = 7'h4F;
      4'h4: encode = 7'h66;  4'h5: encode = 7'h6D;
      4'h6: encode = 7'h7D;  4'h7: encode = 7'h07;
      4'h8: encode = 7'h7F;  4'h9: encode = 7'h6F;
      4'hA: encode = 7'h77;  4'hB: encode = 7'h7C;
      4'hC: encode = 7'h39;  4'hD: encode = 7'h5E;
      4'hE: encode = 7'h79;  default: encode = 7'h71;
    endcase
  endfunction

  // Digit 0 is never suppressed as a leading zero; only its blank bit can darken it.
  function automatic logic digit_dark(input logic [15:0] d, input logic [3:0] b,
                                      input logic lz, input logic [1:0] i);
    logic hz;
    case (i)
      2'd1:    hz = (d[15:4] == 12'h000);
      2'd2:    hz = (d[15:8] == 8'h00);
      2'd3:    hz = (d[15:12] == 4'h0);
      default: hz = 1'b0;
    endcase
    digit_dark = b[i] | (lz & hz);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    act_data_d  = act_data_q;
    act_blank_d = act_blank_q;
    act_lz_d    = act_lz_q;
    pnd_data_d  = pnd_data_q;
    pnd_blank_d = pnd_blank_q;
    pnd_lz_d    = pnd_lz_q;
    pend_d      = pend_q;
    seg_d       = seg_q;
    dig_en_d    = dig_en_q;

    // valid/ready: a transfer happens on any edge where load_valid && load_ready.
    if (load_valid && !pend_q) begin
      pnd_data_d  = data_in;
      pnd_blank_d = blank_in;
      pnd_lz_d    = lz_en_in;
      pend_d      = 1'b1;
    end

    if (state_q == S_DRIVE && cnt_q == DIV_LAST) begin
      state_d  = S_GAP;
      cnt_d    = '0;
      seg_d    = 7'h00;
      dig_en_d = 4'h0;
    end else if (state_q == S_GAP && cnt_q == GAP_LAST) begin
      state_d = S_DRIVE;
      cnt_d   = '0;
      idx_d   = idx_q + 2'd1;
      if (idx_q == 2'd3 && pend_q) begin
        act_data_d  = pnd_data_q;
        act_blank_d = pnd_blank_q;
        act_lz_d    = pnd_lz_q;
        pend_d      = 1'b0;
      end
      if (digit_dark(act_data_d, act_blank_d, act_lz_d, idx_d)) begin
        seg_d    = 7'h00;
        dig_en_d = 4'h0;
      end else begin
        seg_d    = encode(act_data_d[{idx_d, 2'b00} +: 4]);
        dig_en_d = 4'b0001 << idx_d;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    frame_done_d = (state_d == S_GAP) && (idx_d == 2'd3) && (cnt_d == GAP_LAST);
  end

  // Reset parks the scan at the last cycle of GAP(3) so the first edge enters DRIVE(0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_GAP;
      idx_q        <= 2'd3;
      cnt_q        <= GAP_LAST;
      act_data_q   <= 16'h0000;
      act_blank_q  <= 4'h0;
      act_lz_q     <= 1'b0;
      pnd_data_q   <= 16'h0000;
      pnd_blank_q  <= 4'h0;
      pnd_lz_q     <= 1'b0;
      pend_q       <= 1'b0;
      seg_q        <= 7'h00;
      dig_en_q     <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      act_data_q   <= act_data_d;
      act_blank_q  <= act_blank_d;
      act_lz_q     <= act_lz_d;
      pnd_data_q   <= pnd_data_d;
      pnd_blank_q  <= pnd_blank_d;
      pnd_lz_q     <= pnd_lz_d;
      pend_q       <= pend_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = !pend_q;
  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4, GAP=2 (24-cycle frame).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic        lz_en_in;
  logic        load_valid;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  seg_scan_ctrl #(.DIV(4), .GAP(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .lz_en_in   (lz_en_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  blank;
    logic        lz;
    logic [3:0]  lit;   // digits expected to be driven
    logic [27:0] segs;  // {d3,d2,d1,d0} expected segment codes
  } vec_t;

  vec_t v_zero, v_1a2f, v_1234;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One sampled cycle k (0..23) of a frame that displays rec.
  task automatic check_cycle(input vec_t rec, input int k);
    int d, p;
    logic on;
    d  = k / 6;
    p  = k % 6;
    on = (p < 4) && rec.lit[d];
    check($sformatf("seg d%0d k%0d", d, k), {25'd0, seg}, on ? {25'd0, rec.segs[d*7 +: 7]} : 32'd0);
    check($sformatf("dig_en d%0d k%0d", d, k), {28'd0, dig_en}, on ? (32'd1 << d) : 32'd0);
    check($sformatf("frame_done k%0d", k), {31'd0, frame_done}, (k == 23) ? 32'd1 : 32'd0);
    if (k == 0) check("load_ready frame start", {31'd0, load_ready}, 32'd1);
  endtask

  // Called at the negedge just before the frame's first edge.
  task automatic frame(input vec_t rec);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check_cycle(rec, k);
    end
  endtask

  task automatic load_value(input logic [15:0] d, input logic [3:0] b, input logic lz);
    data_in    = d;
    blank_in   = b;
    lz_en_in   = lz;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check("load_ready after accept", {31'd0, load_ready}, 32'd0);
  endtask

  task automatic wait_frame_done();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    check("wait frame_done", {31'd0, found}, 32'd1);
  endtask

  initial begin
    v_zero = '{16'h0000, 4'b0000, 1'b0, 4'b1111, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    v_1a2f = '{16'h1A2F, 4'b0000, 1'b0, 4'b1111, {7'h06, 7'h77, 7'h5B, 7'h71}};
    v_1234 = '{16'h1234, 4'b0000, 1'b0, 4'b1111, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    tbl[0] = '{16'h0050, 4'b0000, 1'b1, 4'b0011, {7'h00, 7'h00, 7'h6D, 7'h3F}};
    tbl[1] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3F}};
    tbl[2] = '{16'h8888, 4'b0101, 1'b0, 4'b1010, {7'h7F, 7'h00, 7'h7F, 7'h00}};
    tbl[3] = '{16'h0F00, 4'b0000, 1'b1, 4'b0111, {7'h00, 7'h71, 7'h3F, 7'h3F}};
    tbl[4] = '{16'h00B0, 4'b1000, 1'b0, 4'b0111, {7'h00, 7'h3F, 7'h7C, 7'h3F}};

    rst_n      = 1'b0;
    data_in    = 16'h0000;
    blank_in   = 4'h0;
    lz_en_in   = 1'b0;
    load_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset seg", {25'd0, seg}, 32'd0);
    check("reset dig_en", {28'd0, dig_en}, 32'd0);
    check("reset load_ready", {31'd0, load_ready}, 32'd1);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // First frame shows zeros; 1A2F accepted mid-frame must wait for the boundary.
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check_cycle(v_zero, k);
      if (k == 9) begin
        data_in    = 16'h1A2F;
        load_valid = 1'b1;
      end
      if (k == 10) begin
        check("load_ready after mid-frame accept", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
      end
    end
    frame(v_1a2f);

    // Backpressure: 5678 offered while pending is full is ignored.
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check_cycle(v_1a2f, k);
      if (k == 3) begin
        data_in    = 16'h1234;
        load_valid = 1'b1;
      end
      if (k == 4) begin
        check("load_ready backpressure", {31'd0, load_ready}, 32'd0);
        data_in = 16'h5678;
      end
      if (k == 21) load_valid = 1'b0;
    end
    frame(v_1234);
    frame(v_1234);

    // Table-driven: leading-zero suppression and blank mask.
    for (int i = 0; i < 5; i++) begin
      load_value(tbl[i].data, tbl[i].blank, tbl[i].lz);
      wait_frame_done();
      frame(tbl[i]);
    end

    // Reset during DRIVE(2) with a pending value: cleared at once, pending discarded.
    load_value(16'h1234, 4'h0, 1'b0);
    repeat (13) @(negedge clk);
    check("pre-reset dig_en", {28'd0, dig_en}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async reset seg", {25'd0, seg}, 32'd0);
    check("async reset dig_en", {28'd0, dig_en}, 32'd0);
    check("async reset load_ready", {31'd0, load_ready}, 32'd1);
    check("async reset frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(v_zero);
    frame(v_zero);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
